brick_hit_handler: RTL and testbench

BRICK_HIT_HANDLER -- requirements
Module: brick_hit_handler

---
 rtl/brick_hit_handler.sv | 251 +++++++++++++++++++++++++
 tb/tb_brick_hit_handler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_hit_handler.sv
// ---------------------------------------------------------------------------
// brick_hit_handler
//
// Takes one qualified brick/ball collision per scan pass and turns it into:
//   - a level-memory write that damages or removes the brick,
//   - a reflected ball direction with a one-cycle strobe,
//   - score and remaining-brick bookkeeping, including a sticky level-clear.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   brickBallCollide in   qualified collision from the brick scanner
//   collideDir [2:0] in   000 Left, 001 Right, 010 Top, 011 Down, 100 None
//   brick_x    [3:0] in   scanner column of the brick under test
//   brick_y    [3:0] in   scanner row of the brick under test
//   brick_type [3:0] in   level-memory read data for that brick
//   ballcheckReset   in   start of a new scan pass
//   ball_dir   [1:0] in   current ball direction (bit1 = up, bit0 = right)
//   level_load       in   load a new destructible-brick count
//   level_bricks [6:0] in count loaded by level_load
//   wr_en            out  level-memory write enable (one cycle)
//   wr_x/wr_y  [3:0] out  write address
//   wr_type    [3:0] out  write data (damaged brick type)
//   new_dir    [1:0] out  reflected ball direction, held between hits
//   dir_valid        out  one-cycle strobe qualifying new_dir
//   score     [15:0] out  saturating score
//   bricks_left [6:0] out destructible bricks remaining
//   level_clear      out  sticky, set when the last brick is removed
//   busy             out  high while a hit is being applied
// ---------------------------------------------------------------------------
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for the first collision of the current scan pass
//  UPDATE | applying the latched hit: write, reflect, score (one cycle)
// ---------------------------------------------------------------------------
module brick_hit_handler (
    input  logic        clk,
    input  logic        reset,
    input  logic        brickBallCollide,
    input  logic [2:0]  collideDir,
    input  logic [3:0]  brick_x,
    input  logic [3:0]  brick_y,
    input  logic [3:0]  brick_type,
    input  logic        ballcheckReset,
    input  logic [1:0]  ball_dir,
    input  logic        level_load,
    input  logic [6:0]  level_bricks,
    output logic        wr_en,
    output logic [3:0]  wr_x,
    output logic [3:0]  wr_y,
    output logic [3:0]  wr_type,
    output logic [1:0]  new_dir,
    output logic        dir_valid,
    output logic [15:0] score,
    output logic [6:0]  bricks_left,
    output logic        level_clear,
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    localparam logic [3:0] T_NOBRICK = 4'd0;
    localparam logic [3:0] T_RED     = 4'd1;
    localparam logic [3:0] T_BROWN   = 4'd2;
    localparam logic [3:0] T_SRED    = 4'd3;
    localparam logic [3:0] T_SBROWN  = 4'd4;

    localparam logic [2:0] D_LEFT  = 3'b000;
    localparam logic [2:0] D_RIGHT = 3'b001;
    localparam logic [2:0] D_TOP   = 3'b010;
    localparam logic [2:0] D_DOWN  = 3'b011;

    state_t      state;
    state_t      state_nxt;

    logic        hit_taken;
    logic        hit_accept;

    logic [3:0]  lat_x;
    logic [3:0]  lat_y;
    logic [3:0]  lat_type;
    logic [2:0]  lat_cdir;
    logic [1:0]  lat_ball;
    logic [1:0]  dir_hold;

    logic        destructible;
    logic        removal;
    logic [3:0]  mapped_type;
    logic [4:0]  score_inc;
    logic [16:0] score_sum;
    logic [1:0]  refl_dir;

    // Only one hit per scan pass; collisions seen while busy are dropped.
    assign hit_accept = (state == IDLE) && brickBallCollide && !hit_taken;

    // -----------------------------------------------------------------
    // Hit decode from the latched brick
    // -----------------------------------------------------------------
    always_comb begin
        destructible = 1'b0;
        removal      = 1'b0;
        mapped_type  = T_NOBRICK;
        score_inc    = 5'd0;
        case (lat_type)
            T_RED: begin
                destructible = 1'b1;
                removal      = 1'b1;
                mapped_type  = T_NOBRICK;
                score_inc    = 5'd10;
            end
            T_BROWN: begin
                destructible = 1'b1;
                removal      = 1'b1;
                mapped_type  = T_NOBRICK;
                score_inc    = 5'd20;
            end
            T_SRED: begin
                destructible = 1'b1;
                mapped_type  = T_RED;
                score_inc    = 5'd5;
            end
            T_SBROWN: begin
                destructible = 1'b1;
                mapped_type  = T_BROWN;
                score_inc    = 5'd5;
            end
            default: begin
                // NOBRICK and unknown codes behave as walls: reflect only.
                destructible = 1'b0;
            end
        endcase
    end

    // Reflection forces one axis bit and keeps the other; any code that
    // is not a face hit (None and the unused codes) reverses the ball.
    always_comb begin
        case (lat_cdir)
            D_TOP:   refl_dir = {1'b1, lat_ball[0]};
            D_DOWN:  refl_dir = {1'b0, lat_ball[0]};
            D_LEFT:  refl_dir = {lat_ball[1], 1'b0};
            D_RIGHT: refl_dir = {lat_ball[1], 1'b1};
            default: refl_dir = ~lat_ball;
        endcase
    end

    // 17-bit sum so the carry out flags saturation.
    assign score_sum = {1'b0, score} + {12'd0, score_inc};

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hit_accept) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------
    always_comb begin
        busy      = (state == UPDATE);
        dir_valid = (state == UPDATE);
        wr_en     = (state == UPDATE) && destructible;
        wr_x      = lat_x;
        wr_y      = lat_y;
        wr_type   = mapped_type;
        new_dir   = (state == UPDATE) ? refl_dir : dir_hold;
    end

    // -----------------------------------------------------------------
    // Hit capture and pass bookkeeping
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_taken <= 1'b0;
            lat_x     <= 4'd0;
            lat_y     <= 4'd0;
            lat_type  <= 4'd0;
            lat_cdir  <= 3'd0;
            lat_ball  <= 2'd0;
        end else begin
            if (hit_accept) begin
                hit_taken <= 1'b1;
                lat_x     <= brick_x;
                lat_y     <= brick_y;
                lat_type  <= brick_type;
                lat_cdir  <= collideDir;
                lat_ball  <= ball_dir;
            end else if (ballcheckReset) begin
                hit_taken <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------
    // Direction hold, score, brick count, level clear
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_hold    <= 2'd0;
            score       <= 16'd0;
            bricks_left <= 7'd0;
            level_clear <= 1'b0;
        end else begin
            if (state == UPDATE) begin
                dir_hold <= refl_dir;
                if (destructible) begin
                    score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
            end

            // A new level load wins over a removal on the same edge.
            if (level_load) begin
                bricks_left <= level_bricks;
                level_clear <= 1'b0;
            end else if ((state == UPDATE) && removal && (bricks_left != 7'd0)) begin
                bricks_left <= bricks_left - 7'd1;
                if (bricks_left == 7'd1) begin
                    level_clear <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_hit_handler.sv
module tb_brick_hit_handler;

    logic        clk;
    logic        reset;
    logic        brickBallCollide;
    logic [2:0]  collideDir;
    logic [3:0]  brick_x;
    logic [3:0]  brick_y;
    logic [3:0]  brick_type;
    logic        ballcheckReset;
    logic [1:0]  ball_dir;
    logic        level_load;
    logic [6:0]  level_bricks;
    logic        wr_en;
    logic [3:0]  wr_x;
    logic [3:0]  wr_y;
    logic [3:0]  wr_type;
    logic [1:0]  new_dir;
    logic        dir_valid;
    logic [15:0] score;
    logic [6:0]  bricks_left;
    logic        level_clear;
    logic        busy;

    brick_hit_handler dut (
        .clk              (clk),
        .reset            (reset),
        .brickBallCollide (brickBallCollide),
        .collideDir       (collideDir),
        .brick_x          (brick_x),
        .brick_y          (brick_y),
        .brick_type       (brick_type),
        .ballcheckReset   (ballcheckReset),
        .ball_dir         (ball_dir),
        .level_load       (level_load),
        .level_bricks     (level_bricks),
        .wr_en            (wr_en),
        .wr_x             (wr_x),
        .wr_y             (wr_y),
        .wr_type          (wr_type),
        .new_dir          (new_dir),
        .dir_valid        (dir_valid),
        .score            (score),
        .bricks_left      (bricks_left),
        .level_clear      (level_clear),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] t;
        logic [1:0] nd;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit   m_hit_taken;
    int   m_score;
    int   m_bricks;
    bit   m_clear;
    logic [1:0] m_dir;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected hit.
    always @(negedge clk) begin
        exp_t e;
        if (dir_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("upd_wr_en", 32'(wr_en), 32'(e.wr_en));
                if (e.wr_en) begin
                    check_val("upd_wr_x", 32'(wr_x), 32'(e.x));
                    check_val("upd_wr_y", 32'(wr_y), 32'(e.y));
                    check_val("upd_wr_type", 32'(wr_type), 32'(e.t));
                end
                check_val("upd_new_dir", 32'(new_dir), 32'(e.nd));
                check_val("upd_busy", 32'(busy), 32'd1);
            end
        end else if (wr_en === 1'b1 || busy === 1'b1) begin
            check_val("idle_strobe", 32'({wr_en, busy}), 32'd0);
        end
    end

    function automatic logic [1:0] model_refl(input logic [2:0] cd, input logic [1:0] bd);
        case (cd)
            3'b010:  return {1'b1, bd[0]};
            3'b011:  return {1'b0, bd[0]};
            3'b000:  return {bd[1], 1'b0};
            3'b001:  return {bd[1], 1'b1};
            default: return ~bd;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hit_taken = 0;
        m_score     = 0;
        m_bricks    = 0;
        m_clear     = 0;
        m_dir       = 2'b00;
    endtask

    task automatic load(input int n);
        level_load   = 1'b1;
        level_bricks = 7'(n);
        cyc();
        level_load   = 1'b0;
        m_bricks     = n;
        m_clear      = 0;
    endtask

    task automatic new_pass();
        ballcheckReset = 1'b1;
        cyc();
        ballcheckReset = 1'b0;
        m_hit_taken    = 0;
    endtask

    task automatic hit(input logic [3:0] x, input logic [3:0] y, input logic [3:0] t,
                       input logic [2:0] cd, input logic [1:0] bd,
                       input bit ld_at_upd, input int ld_val, input bit rst_at_upd);
        bit   accept;
        exp_t e;
        int   inc;
        bit   rem;
        logic [3:0] mt;
        brick_x          = x;
        brick_y          = y;
        brick_type       = t;
        collideDir       = cd;
        ball_dir         = bd;
        brickBallCollide = 1'b1;
        accept = !m_hit_taken;
        inc = 0; rem = 0; mt = 4'd0;
        case (t)
            4'd1: begin inc = 10; rem = 1; mt = 4'd0; end
            4'd2: begin inc = 20; rem = 1; mt = 4'd0; end
            4'd3: begin inc = 5;  mt = 4'd1; end
            4'd4: begin inc = 5;  mt = 4'd2; end
            default: inc = 0;
        endcase
        if (accept) begin
            e.wr_en = (t >= 4'd1 && t <= 4'd4);
            e.x = x; e.y = y; e.t = mt;
            e.nd = model_refl(cd, bd);
            sb.push_back(e);
            m_hit_taken = 1;
        end
        cyc();
        brickBallCollide = 1'b0;
        if (ld_at_upd) begin
            level_load   = 1'b1;
            level_bricks = 7'(ld_val);
        end
        if (rst_at_upd) reset = 1'b1;
        cyc();
        level_load = 1'b0;
        reset      = 1'b0;
        if (rst_at_upd) begin
            model_reset();
        end else begin
            if (accept) begin
                m_dir   = e.nd;
                m_score = (m_score + inc > 65535) ? 65535 : m_score + inc;
                if (rem && m_bricks > 0) begin
                    m_bricks--;
                    if (m_bricks == 0) m_clear = 1;
                end
            end
            if (ld_at_upd) begin
                m_bricks = ld_val;
                m_clear  = 0;
            end
        end
        check_val("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_score"},  32'(score),       32'(m_score));
        check_val({tag, "_bricks"}, 32'(bricks_left), 32'(m_bricks));
        check_val({tag, "_clear"},  32'(level_clear), 32'(m_clear));
        check_val({tag, "_dir"},    32'(new_dir),     32'(m_dir));
    endtask

    initial begin
        reset = 1'b1;
        brickBallCollide = 1'b0;
        collideDir = 3'b100;
        brick_x = 4'd0; brick_y = 4'd0; brick_type = 4'd0;
        ballcheckReset = 1'b0;
        ball_dir = 2'b00;
        level_load = 1'b0;
        level_bricks = 7'd0;
        model_reset();
        repeat (3) cyc();
        reset = 1'b0;

        // reset values
        check_val("rst_wr_en",   32'(wr_en),   32'd0);
        check_val("rst_wr_x",    32'(wr_x),    32'd0);
        check_val("rst_wr_y",    32'(wr_y),    32'd0);
        check_val("rst_wr_type", 32'(wr_type), 32'd0);
        check_val("rst_dir_valid", 32'(dir_valid), 32'd0);
        check_val("rst_busy",    32'(busy),    32'd0);
        check_state("rst");

        // RED at (3,2), Top, ball UpRight-less (01)
        load(5);
        hit(4'd3, 4'd2, 4'd1, 3'b010, 2'b01, 0, 0, 0);
        check_state("red_top");
        new_pass();

        // SRED, Left, ball 11
        hit(4'd5, 4'd6, 4'd3, 3'b000, 2'b11, 0, 0, 0);
        check_state("sred_left");
        new_pass();

        // two collisions in one pass: second ignored
        hit(4'd1, 4'd1, 4'd2, 3'b001, 2'b00, 0, 0, 0);
        hit(4'd7, 4'd8, 4'd1, 3'b010, 2'b00, 0, 0, 0);
        check_state("second_ignored");
        new_pass();
        hit(4'd9, 4'd4, 4'd1, 3'b011, 2'b10, 0, 0, 0);
        check_state("after_pass");
        new_pass();

        // drive bricks_left to 1, then BROWN clears the level
        hit(4'd2, 4'd3, 4'd1, 3'b001, 2'b10, 0, 0, 0);
        new_pass();
        check_val("one_left", 32'(bricks_left), 32'd1);
        hit(4'd4, 4'd4, 4'd2, 3'b010, 2'b00, 0, 0, 0);
        check_state("level_clear");
        new_pass();
        load(12);
        check_state("reload12");

        // removal at zero stays zero and does not re-assert level_clear
        load(0);
        hit(4'd1, 4'd2, 4'd1, 3'b000, 2'b01, 0, 0, 0);
        check_state("zero_sat");
        new_pass();

        // level_load on the removal edge wins for the count
        load(3);
        hit(4'd6, 4'd7, 4'd2, 3'b011, 2'b11, 1, 9, 0);
        check_state("load_priority");
        new_pass();

        // indestructible type 7, None, ball 00
        hit(4'd8, 4'd9, 4'd7, 3'b100, 2'b00, 0, 0, 0);
        check_state("indestructible");
        new_pass();

        // SBROWN, Right
        hit(4'd10, 4'd11, 4'd4, 3'b001, 2'b10, 0, 0, 0);
        check_state("sbrown");
        new_pass();

        // climb to near the top of the score range, then saturate
        load(127);
        while (m_score + 20 < 32'hFFF8) begin
            hit(4'($urandom_range(15)), 4'($urandom_range(15)), 4'd2,
                3'($urandom_range(4)), 2'($urandom_range(3)), 0, 0, 0);
            new_pass();
        end
        while (m_score + 5 <= 32'hFFF8) begin
            hit(4'd0, 4'd0, 4'd3, 3'b010, 2'b00, 0, 0, 0);
            new_pass();
        end
        check_state("near_top");
        hit(4'd1, 4'd1, 4'd2, 3'b010, 2'b01, 0, 0, 0);
        check_val("sat_ffff", 32'(score), 32'hFFFF);
        new_pass();
        hit(4'd2, 4'd2, 4'd1, 3'b000, 2'b11, 0, 0, 0);
        check_state("sat_hold");
        new_pass();

        // reset during UPDATE: nothing completes
        hit(4'd3, 4'd3, 4'd1, 3'b010, 2'b00, 0, 0, 1);
        check_val("midrst_wr_en", 32'(wr_en), 32'd0);
        check_val("midrst_dir_valid", 32'(dir_valid), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_wr_x", 32'(wr_x), 32'd0);
        check_state("midrst");

        // hit_taken cleared by reset: first hit after reset is accepted
        load(2);
        hit(4'd12, 4'd13, 4'd1, 3'b001, 2'b00, 0, 0, 0);
        check_state("post_reset_hit");

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
